// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle data_valid / frame_error strobes and a held output byte.
module uart_byte_rx #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int CNT_W        = 14
) (
  input  logic       uart_clk,
  input  logic       rst,
  input  logic       rx,
  output logic       data_valid,
  output logic [7:0] data_receive,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BREAK = 3'd4;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [1:0]       sync_reg;
  logic             rx_s;
  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_reg, data_next;
  logic             dv_reg, dv_next;
  logic             fe_reg, fe_next;
  logic             data_sample;

  assign rx_s = sync_reg[1];

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    idx_next    = idx_reg;
    dv_next     = 1'b0;
    fe_next     = 1'b0;
    data_sample = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          state_next = START;
          cnt_next   = '0;
        end
      end
      START: begin
        // A start bit that is high again at its midpoint is treated as a glitch.
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next    = '0;
          data_sample = 1'b1;
          idx_next    = idx_reg + 3'd1;
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      STOP: begin
        // Leaving at mid stop bit gives half a bit of slack for the next start edge.
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s) begin
            dv_next    = 1'b1;
            state_next = IDLE;
          end else begin
            fe_next    = 1'b1;
            state_next = BREAK;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_shift
      assign shift_next[gi] = (data_sample && (idx_reg == 3'(gi))) ? rx_s : shift_reg[gi];
    end
  endgenerate

  assign data_next = dv_next ? shift_reg : data_reg;

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      sync_reg  <= 2'b11;
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= 8'h00;
      data_reg  <= 8'h00;
      dv_reg    <= 1'b0;
      fe_reg    <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], rx};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      data_reg  <= data_next;
      dv_reg    <= dv_next;
      fe_reg    <= fe_next;
    end
  end

  assign data_valid   = dv_reg;
  assign frame_error  = fe_reg;
  assign data_receive = data_reg;
  assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: directed frame table, hand-written
// glitch/break/reset sequences, then random frames against a byte-level model.
module tb_uart_byte_rx;

  localparam int CPB = 16;

  logic       uart_clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       data_valid;
  logic [7:0] data_receive;
  logic       frame_error;
  logic       busy;

  uart_byte_rx #(.CLKS_PER_BIT(CPB), .CNT_W(5)) dut (
    .uart_clk    (uart_clk),
    .rst         (rst),
    .rx          (rx),
    .data_valid  (data_valid),
    .data_receive(data_receive),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 uart_clk = ~uart_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge uart_clk) cyc <= cyc + 1;

  // Passive monitor: pulse counts, captured byte, pulse-shape violations.
  int         dv_count = 0;
  int         fe_count = 0;
  int         busy_cycles = 0;
  int         dv_cyc = 0;
  int         pulse_bad = 0;
  logic [7:0] dv_byte = 8'h00;
  logic       dv_prev = 1'b0;
  logic       fe_prev = 1'b0;

  always @(negedge uart_clk) begin
    if (data_valid === 1'b1) begin
      dv_count++;
      dv_cyc  = cyc;
      dv_byte = data_receive;
    end
    if (frame_error === 1'b1) fe_count++;
    if (busy === 1'b1) busy_cycles++;
    if ((data_valid && frame_error) || (data_valid && dv_prev) || (frame_error && fe_prev))
      pulse_bad++;
    dv_prev = data_valid;
    fe_prev = frame_error;
  end

  logic [7:0] model_held = 8'h00;
  int         start_cyc = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic [7:0] exp_held;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive_bits(input logic v, input int n);
    if (n > 0) begin
      rx = v;
      repeat (n) @(negedge uart_clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int gap);
    start_cyc = cyc;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bits(d[i], CPB);
    drive_bits(stop, CPB);
    drive_bits(1'b1, gap);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic stop, input int gap,
                           input logic [7:0] exp_held, input string tag);
    int dv0 = dv_count;
    int fe0 = fe_count;
    int pb0 = pulse_bad;
    int lat;
    send_frame(d, stop, gap);
    check({tag, "_dv_pulses"}, 32'(dv_count - dv0), stop ? 32'd1 : 32'd0);
    check({tag, "_fe_pulses"}, 32'(fe_count - fe0), stop ? 32'd0 : 32'd1);
    check({tag, "_held_byte"}, {24'h0, data_receive}, {24'h0, exp_held});
    check({tag, "_pulse_shape"}, 32'(pulse_bad - pb0), 32'd0);
    if (stop) begin
      check({tag, "_byte_at_pulse"}, {24'h0, dv_byte}, {24'h0, d});
      lat = dv_cyc - start_cyc;
      checks++;
      if (lat < 2 + CPB / 2 + 9 * CPB || lat > 2 + CPB / 2 + 9 * CPB + 2) begin
        errors++;
        $display("FAIL %s_latency actual=%0d required=%0d+-1", tag, lat, 2 + CPB / 2 + 9 * CPB + 1);
      end
    end
    $display("frame %s data=%02h stop=%0b -> data_receive=%02h dv=%0d fe=%0d",
             tag, d, stop, data_receive, dv_count - dv0, fe_count - fe0);
  endtask

  initial begin
    int dv0;
    int fe0;
    int b0;
    logic [7:0] d;
    logic       s;
    int         g;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge uart_clk);
    rst = 1'b0;

    // Idle line after reset.
    repeat (100) @(negedge uart_clk);
    check("idle_dv", 32'(dv_count), 32'd0);
    check("idle_fe", 32'(fe_count), 32'd0);
    check("idle_busy_cycles", 32'(busy_cycles), 32'd0);
    check("idle_data", {24'h0, data_receive}, 32'h0);

    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: 20, exp_held: 8'hA5};
    vecs[1] = '{data: 8'h0D, stop: 1'b1, gap: 0,  exp_held: 8'h0D};
    vecs[2] = '{data: 8'h36, stop: 1'b1, gap: 0,  exp_held: 8'h36};
    vecs[3] = '{data: 8'hFF, stop: 1'b1, gap: 24, exp_held: 8'hFF};
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].data, vecs[i].stop, vecs[i].gap, vecs[i].exp_held, $sformatf("vec%0d", i));
      model_held = vecs[i].exp_held;
    end

    // Start glitch: low for 5 cycles only.
    dv0 = dv_count; fe0 = fe_count; b0 = busy_cycles;
    drive_bits(1'b0, 5);
    drive_bits(1'b1, 30);
    check("glitch_dv", 32'(dv_count - dv0), 32'd0);
    check("glitch_fe", 32'(fe_count - fe0), 32'd0);
    checks++;
    if (busy_cycles - b0 < 1 || busy_cycles - b0 > CPB / 2 + 2) begin
      errors++;
      $display("FAIL glitch_busy_cycles actual=%0d required=1..%0d", busy_cycles - b0, CPB / 2 + 2);
    end
    $display("glitch busy_cycles=%0d", busy_cycles - b0);

    // Bad stop bit followed by a held-low line.
    dv0 = dv_count; fe0 = fe_count;
    send_frame(8'h3C, 1'b0, 0);
    drive_bits(1'b0, 50);
    check("break_fe", 32'(fe_count - fe0), 32'd1);
    check("break_dv", 32'(dv_count - dv0), 32'd0);
    check("break_held", {24'h0, data_receive}, {24'h0, model_held});
    check("break_busy_low_line", {31'h0, busy}, 32'd1);
    drive_bits(1'b1, CPB);
    check("break_busy_after_high", {31'h0, busy}, 32'd0);
    $display("break sequence fe=%0d data_receive=%02h", fe_count - fe0, data_receive);
    run_frame(8'h11, 1'b1, 20, 8'h11, "after_break");
    model_held = 8'h11;

    // Reset during the data bits of 8'hF0.
    d = 8'hF0;
    dv0 = dv_count;
    drive_bits(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bits(d[i], CPB);
    drive_bits(d[4], CPB / 2);
    rst = 1'b1;
    @(negedge uart_clk);
    rst = 1'b0;
    check("midreset_busy", {31'h0, busy}, 32'd0);
    check("midreset_data", {24'h0, data_receive}, 32'h0);
    drive_bits(1'b1, 3 * CPB);
    check("midreset_no_dv", 32'(dv_count - dv0), 32'd0);
    $display("mid-frame reset busy=%0b dv=%0d", busy, dv_count - dv0);
    model_held = 8'h00;
    run_frame(8'h5A, 1'b1, 20, 8'h5A, "after_reset");
    model_held = 8'h5A;

    // Random frames against the byte-level model.
    for (int i = 0; i < 24; i++) begin
      d = 8'($urandom);
      s = ($urandom_range(0, 9) != 0);
      g = s ? int'($urandom_range(0, 30)) : CPB + int'($urandom_range(0, 20));
      if (s) model_held = d;
      run_frame(d, s, g, model_held, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
